// File: rtl/rf_pkg.sv
// Shared constants for the register-file write-back path.
package rf_pkg;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam int NREQ = 3;

  localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rf_wb_rr_arb.sv
// One-hot grant over write-back requesters.
// RF_WB_RR_EN selects round-robin; otherwise fixed priority.
module rf_wb_rr_arb
  import rf_pkg::*;
#(
  parameter int NREQ = rf_pkg::NREQ
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant
);

  logic found;

`ifdef RF_WB_RR_EN
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  int            idx;

  // Pointer only moves when a grant is issued,
  // and every grant is a completed transfer.
  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!found && j == idx && req[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          ptr_nxt  = PW'((j + 1) % NREQ);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end
`else
  logic unused_clk;

  assign unused_clk = clk ^ rst_n;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter with RAW scoreboard.
// Define RF_WB_RR_EN for round-robin arbitration.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = rf_pkg::NREQ,
  parameter int AW   = rf_pkg::AW,
  parameter int DW   = rf_pkg::DW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              RegWr,
  output logic [AW-1:0]     RW,
  output logic [DW-1:0]     busW,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic [AW-1:0]     qa,
  input  logic [AW-1:0]     qb,
  output logic              busy_a,
  output logic              busy_b,
  output logic [NREG-1:0]   pending,
  output logic              sb_err
);

  logic [NREQ-1:0] grant;
  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;
  logic            xfer;

  rf_wb_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .clk   (clock),
    .rst_n (reset),
    .req   (req_valid),
    .grant (grant)
  );

  assign req_ready = grant & {NREQ{reset}};
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant[j]) begin
        sel_rd   = req_rd[j*AW +: AW];
        sel_data = req_data[j*DW +: DW];
      end
    end
  end

  // $0 transfers are accepted but never raise the write enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      RegWr <= 1'b0;
      RW    <= '0;
      busW  <= '0;
    end else begin
      RegWr <= xfer && (sel_rd != AW'(REG_ZERO));
      if (xfer) begin
        RW   <= sel_rd;
        busW <= sel_data;
      end
    end
  end

  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] pend_nxt;
  logic            iss_err;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      if (iss_valid && iss_rd == AW'(r)) begin
        set_vec[r] = 1'b1;
      end
      if (RegWr && RW == AW'(r)) begin
        clr_vec[r] = 1'b1;
      end
    end
    set_vec[REG_ZERO] = 1'b0;
    // Set after clear so a same-edge reissue keeps the bit.
    pend_nxt           = (pending & ~clr_vec) | set_vec;
    pend_nxt[REG_ZERO] = 1'b0;
    iss_err            = |(set_vec & pending & ~clr_vec);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      sb_err  <= 1'b0;
    end else begin
      pending <= pend_nxt;
      if (iss_err) begin
        sb_err <= 1'b1;
      end
    end
  end

  assign busy_a = pending[qa];
  assign busy_b = pending[qb];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter.
// Expectations follow RF_WB_RR_EN when it is defined.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic            clock;
  logic            reset;
  logic [2:0]      req_valid;
  logic [14:0]     req_rd;
  logic [95:0]     req_data;
  logic [2:0]      req_ready;
  logic            RegWr;
  logic [4:0]      RW;
  logic [31:0]     busW;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [4:0]      qa;
  logic [4:0]      qb;
  logic            busy_a;
  logic            busy_b;
  logic [31:0]     pending;
  logic            sb_err;

  int n_cmp;
  int n_bad;

  rf_wb_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .RegWr     (RegWr),
    .RW        (RW),
    .busW      (busW),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .qa        (qa),
    .qb        (qb),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .pending   (pending),
    .sb_err    (sb_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [2:0] exp_g;
  logic [4:0] exp_rd;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b0;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    qa        = '0;
    qb        = '0;
    tick();
    tick();
    req_valid = 3'b111;
    #1;
    chk("rst_we", RegWr, 1'b0);
    chk("rst_rw", RW, 5'd0);
    chk("rst_busw", busW, 32'd0);
    chk("rst_pend", pending, 32'd0);
    chk("rst_err", sb_err, 1'b0);
    chk("rst_rdy", req_ready, 3'b000);

    // Mid-stream async reset
    tick();
    reset    = 1'b1;
    req_rd   = {5'd3, 5'd2, 5'd1};
    req_data = {32'h3333, 32'h2222, 32'h1111};
    iss_valid = 1'b1;
    iss_rd    = 5'd1;
    #1;
    chk("rel_rdy", req_ready, 3'b001);
    tick();
    iss_valid = 1'b0;
    chk("mid_we", RegWr, 1'b1);
    chk("mid_pend", pending, 32'h2);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_we", RegWr, 1'b0);
    chk("ar_pend", pending, 32'd0);
    chk("ar_rdy", req_ready, 3'b000);
    tick();
    reset = 1'b1;
    #1;
    chk("post_rdy", req_ready, 3'b001);
    req_valid = 3'b000;

    // Single write from requester 1
    tick();
    req_valid = 3'b010;
    req_rd    = {5'd0, 5'd7, 5'd0};
    req_data  = {32'h0, 32'hDEADBEEF, 32'h0};
    #1;
    chk("sw_rdy", req_ready, 3'b010);
    tick();
    req_valid = 3'b000;
    chk("sw_we", RegWr, 1'b1);
    chk("sw_rw", RW, 5'd7);
    chk("sw_busw", busW, 32'hDEADBEEF);
    tick();
    chk("sw_we2", RegWr, 1'b0);
    chk("sw_hold", RW, 5'd7);

    // Contention, pointer freshly reset
    reset = 1'b0;
    #1;
    reset     = 1'b1;
    req_valid = 3'b111;
    req_rd    = {5'd12, 5'd11, 5'd10};
    req_data  = {32'hC, 32'hB, 32'hA};
    for (int i = 0; i < 6; i++) begin
`ifdef RF_WB_RR_EN
      exp_g  = 3'b001 << (i % 3);
      exp_rd = 5'(10 + (i % 3));
`else
      exp_g  = 3'b001;
      exp_rd = 5'd10;
`endif
      #1;
      chk("ct_rdy", req_ready, exp_g);
      tick();
      chk("ct_we", RegWr, 1'b1);
      chk("ct_rw", RW, exp_rd);
    end
    req_valid = 3'b000;
    tick();
    chk("ct_idle", RegWr, 1'b0);

    // Scoreboard set / clear / same-edge
    qa        = 5'd5;
    qb        = 5'd6;
    iss_valid = 1'b1;
    iss_rd    = 5'd5;
    tick();
    iss_valid = 1'b0;
    chk("sb_set", pending, 32'h20);
    chk("sb_busya", busy_a, 1'b1);
    chk("sb_busyb", busy_b, 1'b0);
    req_valid = 3'b001;
    req_rd    = {5'd0, 5'd0, 5'd5};
    req_data  = {32'h0, 32'h0, 32'h55};
    tick();
    req_valid = 3'b000;
    chk("sb_xfer", busy_a, 1'b1);
    tick();
    chk("sb_clr", pending, 32'd0);
    chk("sb_clra", busy_a, 1'b0);
    iss_valid = 1'b1;
    tick();
    iss_valid = 1'b0;
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    iss_valid = 1'b1;
    tick();
    iss_valid = 1'b0;
    chk("sb_same", pending, 32'h20);
    chk("sb_same_err", sb_err, 1'b0);
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    tick();
    chk("sb_clr2", pending, 32'd0);

    // Register zero
    req_valid = 3'b001;
    req_rd    = '0;
    req_data  = {32'h0, 32'h0, 32'h123};
    #1;
    chk("z_rdy", req_ready, 3'b001);
    tick();
    req_valid = 3'b000;
    chk("z_we", RegWr, 1'b0);
    iss_valid = 1'b1;
    iss_rd    = 5'd0;
    tick();
    iss_valid = 1'b0;
    chk("z_pend", pending, 32'd0);
    chk("z_err", sb_err, 1'b0);

    // Double issue
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    tick();
    tick();
    iss_valid = 1'b0;
    chk("di_err", sb_err, 1'b1);
    chk("di_pend", pending, 32'h200);
    req_valid = 3'b001;
    req_rd    = {5'd0, 5'd0, 5'd9};
    tick();
    req_valid = 3'b000;
    tick();
    chk("di_clr", pending, 32'd0);
    chk("di_sticky", sb_err, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
